fir_mac_core: RTL

- Serial-MAC signed FIR filter core that feeds the tt_um_FIR top.
- The top drives samples from ui_in and presents filtered results on its outputs.
- One multiply-accumulate per clock over TAPS taps; valid/ready handshake on the input and output sides.
- Runtime-writable coefficient bank, writable only while idle.

---
 rtl/fir_mac_core.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fir_mac_core.sv
// fir_mac_core: serial multiply-accumulate signed FIR filter core.
// One sample is accepted in IDLE, TAPS products are accumulated one per
// clock in MAC, and the result is offered in OUT until the consumer takes it.
// The coefficient bank powers up as a passthrough and is writable only in IDLE.
module fir_mac_core #(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int TAPS   = 4,
   parameter int AW     = 2,
   parameter int ACC_W  = 18
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              coef_wr,
   input  logic [AW-1:0]     coef_addr,
   input  logic [COEF_W-1:0] coef_data,
   output logic [ACC_W-1:0]  out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy
);

   localparam int PW = DATA_W + COEF_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [DATA_W-1:0]        x_line [TAPS];
   logic [COEF_W-1:0]        coef   [TAPS];
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  acc_sum;
   logic [AW-1:0]            tap_idx;
   logic signed [PW-1:0]     x_ext;
   logic signed [PW-1:0]     c_ext;
   logic signed [PW-1:0]     prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic                     accept;
   logic                     last_tap;
   logic                     coef_hit;

   assign accept   = (state == IDLE) && in_valid;
   assign last_tap = (tap_idx == AW'(TAPS - 1));
   assign coef_hit = coef_wr && (state == IDLE) && ({1'b0, coef_addr} < (AW+1)'(TAPS));

   assign x_ext    = PW'($signed(x_line[tap_idx]));
   assign c_ext    = PW'($signed(coef[tap_idx]));
   assign prod     = x_ext * c_ext;
   assign prod_ext = ACC_W'(prod);
   assign acc_sum  = acc + prod_ext;

   // State register; reset drops straight back to IDLE so out_valid falls at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and handshake outputs derived purely from the current state.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (accept) state_nxt = MAC;
         end
         MAC: begin
            busy = 1'b1;
            if (last_tap) state_nxt = OUT;
         end
         OUT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Coefficient bank: passthrough after reset, updates only land while idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < TAPS; k++) begin
            coef[k] <= (k == 0) ? COEF_W'(1) : '0;
         end
      end else if (coef_hit) begin
         coef[coef_addr] <= coef_data;
      end
   end

   // Delay line shift on acceptance, then one multiply-accumulate per MAC cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < TAPS; k++) begin
            x_line[k] <= '0;
         end
         acc      <= '0;
         tap_idx  <= '0;
         out_data <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  for (int k = TAPS - 1; k > 0; k--) begin
                     x_line[k] <= x_line[k-1];
                  end
                  x_line[0] <= in_data;
                  acc       <= '0;
                  tap_idx   <= '0;
               end
            end
            MAC: begin
               acc     <= acc_sum;
               tap_idx <= tap_idx + AW'(1);
               if (last_tap) out_data <= acc_sum;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
